eq_biquad_cascade: RTL
======================

Name: eq_biquad_cascade

Overview:
- Parametrised successor to the fixed two-shelf EQ.
- Runs a cascade of NUM_BANDS direct-form-I biquads on one time-multiplexed multiply-accumulate unit, one band after another.
- Coefficients live in a register file that is written at runtime, not in a hard LUT.
- Sits in the audio effect chain between the codec receive path and the downstream effects, on the same i_valid/o_valid sample strobe.

Parameters:
- DATA_W, 16, sample width, signed two's complement.
- COEF_W, 32, coefficient width, signed.
- FRAC_W, 28, fractional bits of each coefficient (default is Q4.28).
- NUM_BANDS, 4, number of cascaded biquad sections (1..8).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_enable  in  1  1 = filter, 0 = bypass.
- i_valid  in  1  one-cycle strobe: i_data holds a new sample.
- i_data  in  DATA_W  input sample.
- i_coef_we  in  1  coefficient write strobe.
- i_coef_band  in  3  target band index.
- i_coef_idx  in  3  coefficient select: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
- i_coef_data  in  COEF_W  coefficient value.
- o_coef_ready  out  1  high when a coefficient write will be accepted.
- o_data  out  DATA_W  filtered sample.
- o_valid  out  1  one-cycle strobe: o_data is valid.
- o_busy  out  1  high while a sample is being processed.
- o_overrun  out  1  one-cycle pulse when an input sample is dropped.

Behaviour:
- Each band computes y = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2.
- Band k output is band k+1 input; the last band's output drives o_data.
- Per-band state x1, x2, y1, y2 is DATA_W wide, stored after saturation.
- Arithmetic:
  - Products are DATA_W+COEF_W bits.
  - Accumulator is DATA_W+COEF_W+4 bits, signed.
  - Result = (acc + 2^(FRAC_W−1)) >>> FRAC_W (round half up), then saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- State machine:
  - IDLE: on i_valid && i_enable, latch i_data, clear band counter and accumulator, go to MAC.
  - MAC: 5 cycles, one term per cycle (b0, b1, b2, a1, a2 in that order), then go to WB.
  - WB: 1 cycle. Round and saturate; shift band state (x2←x1, x1←x, y2←y1, y1←y); the result becomes next band's x.
    - If this was the last band, go to OUT; otherwise increment the band counter and go to MAC.
  - OUT: 1 cycle. Register o_data, pulse o_valid, go to IDLE.
- Latency: i_valid to o_valid = 6·NUM_BANDS+1 cycles (25 at default).
- o_busy is high in every state except IDLE.
- Overrun: i_valid while o_busy=1 drops the sample and pulses o_overrun for 1 cycle. Processing in flight is unaffected.
- Coefficient writes:
  - o_coef_ready = !o_busy.
  - A write is applied when i_coef_we && o_coef_ready; otherwise it is ignored.
  - i_coef_band ≥ NUM_BANDS or i_coef_idx > 4 is ignored.
  - i_valid and an accepted write in the same IDLE cycle: the write takes effect first, so the sample uses the new value.
- Bypass (i_enable=0):
  - o_data ← i_data and o_valid ← i_valid, registered with 1-cycle latency.
  - All band states are held at 0.
  - If i_enable falls mid-sample, the current sample completes before bypass applies.
- Reset (asynchronous, also mid-operation):
  - State machine → IDLE; all band states 0.
  - Coefficients reset to unity: b0 = 2^FRAC_W, all others 0.
  - o_data=0, o_valid=0, o_busy=0, o_overrun=0, o_coef_ready=1.

Optional Feature:
- Macro EQ_CLIP_DETECT_EN.
- When defined, adds output o_clip (1 bit): sticky flag set by any saturation in any band's WB.
  - Cleared by reset, or by a coefficient write with i_coef_idx=7.
- When undefined, the port is absent and no detection logic is built.

Test Plan:
All scenarios use default parameters.
1. After reset with no writes, i_data=1000 → o_data=1000 with o_valid exactly 25 cycles after i_valid.
2. Band0 b0=134217728 (0.5), i_data=1001 → o_data=501 (round half up).
3. Band0 b0=2^28, a1=−134217728 (−0.5); input impulse 1000 then zeros, one sample every 30 cycles → outputs 1000, 500, 250, 125.
4. Bands 0 and 1 b0=536870912 (2.0), i_data=20000 → o_data=32767; i_data=−20000 → −32768; o_clip set when EQ_CLIP_DETECT_EN is defined.
5. i_valid repeated 10 cycles after an accepted sample → o_overrun pulses once, that sample produces no o_valid; a coefficient write while busy leaves the coefficient unchanged.
6. Assert i_rst_n=0 at cycle 12 of processing → o_busy=0 and o_valid=0 immediately; the next sample 500 → o_data=500 with unity coefficients; i_enable=0 with i_data=−7 → o_data=−7 after 1 cycle.

Source files
------------

// File: rtl/eq_biquad_cascade.sv
// Cascade of NUM_BANDS direct-form-I biquads sharing one multiply-accumulate unit.
// Latency: i_valid to o_valid is 6*NUM_BANDS+1 cycles when filtering, 1 cycle in bypass.
// Backpressure: none; a sample arriving while busy is dropped and flagged on o_overrun.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_enable              1 = filter, 0 = registered bypass (band states forced to 0)
//   i_valid, i_data       input sample strobe and sample
//   i_coef_we/band/idx/data  runtime coefficient write (idx 0..4 = b0,b1,b2,a1,a2)
//   o_coef_ready          coefficient writes accepted (only while idle)
//   o_data, o_valid       filtered sample and its one-cycle strobe
//   o_busy                high while a sample is in flight
//   o_overrun             one-cycle pulse when an input sample is dropped
//   o_clip                (only with EQ_CLIP_DETECT_EN) sticky saturation flag,
//                         cleared by a coefficient write with idx 7
module eq_biquad_cascade #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 32,
  parameter int FRAC_W    = 28,
  parameter int NUM_BANDS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_coef_we,
  input  logic [2:0]        i_coef_band,
  input  logic [2:0]        i_coef_idx,
  input  logic [COEF_W-1:0] i_coef_data,
  output logic              o_coef_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_overrun
`ifdef EQ_CLIP_DETECT_EN
  ,
  output logic              o_clip
`endif
);

  localparam int PW = DATA_W + COEF_W;      // product width
  localparam int AW = PW + 4;               // accumulator width, headroom for 5 terms
  localparam int BW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

  localparam logic [BW-1:0]            LAST_BAND = BW'(NUM_BANDS - 1);
  localparam logic [COEF_W-1:0]        UNITY     = {{(COEF_W-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
  localparam logic signed [AW-1:0]     HALF      = AW'(1) <<< (FRAC_W - 1);
  localparam logic signed [AW-1:0]     MAXV      = (AW'(1) <<< (DATA_W - 1)) - AW'(1);
  localparam logic signed [AW-1:0]     MINV      = -(AW'(1) <<< (DATA_W - 1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WB,
    S_OUT
  } state_t;

  state_t                   state;
  logic [BW-1:0]            band;
  logic [2:0]               term;
  logic signed [AW-1:0]     acc;
  logic signed [DATA_W-1:0] x_cur;          // input of the band being processed

  logic signed [DATA_W-1:0] x1 [NUM_BANDS];
  logic signed [DATA_W-1:0] x2 [NUM_BANDS];
  logic signed [DATA_W-1:0] y1 [NUM_BANDS];
  logic signed [DATA_W-1:0] y2 [NUM_BANDS];

  logic signed [COEF_W-1:0] c_b0 [NUM_BANDS];
  logic signed [COEF_W-1:0] c_b1 [NUM_BANDS];
  logic signed [COEF_W-1:0] c_b2 [NUM_BANDS];
  logic signed [COEF_W-1:0] c_a1 [NUM_BANDS];
  logic signed [COEF_W-1:0] c_a2 [NUM_BANDS];

  // ---------------------------------------------------------------------------
  // Shared MAC datapath: term selects the operand pair for this cycle.
  // ---------------------------------------------------------------------------
  logic signed [DATA_W-1:0] op_s;
  logic signed [COEF_W-1:0] op_c;
  logic                     op_sub;
  logic signed [PW-1:0]     prod;
  logic signed [AW-1:0]     acc_nxt;

  always_comb begin
    op_s   = x_cur;
    op_c   = c_b0[band];
    op_sub = 1'b0;
    case (term)
      3'd1: begin op_s = x1[band]; op_c = c_b1[band]; end
      3'd2: begin op_s = x2[band]; op_c = c_b2[band]; end
      3'd3: begin op_s = y1[band]; op_c = c_a1[band]; op_sub = 1'b1; end
      3'd4: begin op_s = y2[band]; op_c = c_a2[band]; op_sub = 1'b1; end
      default: ;
    endcase
  end

  assign prod    = PW'(op_s) * PW'(op_c);
  assign acc_nxt = op_sub ? (acc - AW'(prod)) : (acc + AW'(prod));

  // Round half up, drop the fraction, then clamp to the sample range.
  logic signed [AW-1:0]     shr;
  logic                     sat_hi;
  logic                     sat_lo;
  logic signed [DATA_W-1:0] y_sat;

  assign shr    = (acc + HALF) >>> FRAC_W;
  assign sat_hi = (shr > MAXV);
  assign sat_lo = (shr < MINV);
  assign y_sat  = sat_hi ? MAXV[DATA_W-1:0] :
                  sat_lo ? MINV[DATA_W-1:0] : shr[DATA_W-1:0];

  // ---------------------------------------------------------------------------
  // Coefficient register file. Writes only land while idle, so a write in the
  // same cycle as an accepted sample is already visible when the MAC starts.
  // ---------------------------------------------------------------------------
  logic          coef_wr;
  logic          band_ok;
  logic [BW-1:0] wr_band;

  assign coef_wr = i_coef_we && (state == S_IDLE);
  assign band_ok = ({1'b0, i_coef_band} < 4'(NUM_BANDS));
  assign wr_band = i_coef_band[BW-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        c_b0[b] <= UNITY;
        c_b1[b] <= '0;
        c_b2[b] <= '0;
        c_a1[b] <= '0;
        c_a2[b] <= '0;
      end
    end else if (coef_wr && band_ok) begin
      case (i_coef_idx)
        3'd0: c_b0[wr_band] <= i_coef_data;
        3'd1: c_b1[wr_band] <= i_coef_data;
        3'd2: c_b2[wr_band] <= i_coef_data;
        3'd3: c_a1[wr_band] <= i_coef_data;
        3'd4: c_a2[wr_band] <= i_coef_data;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: IDLE -> (MAC x5 -> WB) per band -> OUT -> IDLE.
  // o_data/o_valid are loaded on the last WB edge so the strobe is high
  // during the OUT cycle, giving 6*NUM_BANDS+1 cycles of latency.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      band      <= '0;
      term      <= '0;
      acc       <= '0;
      x_cur     <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        x1[b] <= '0;
        x2[b] <= '0;
        y1[b] <= '0;
        y2[b] <= '0;
      end
    end else begin
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;

      case (state)
        S_IDLE: begin
          if (i_enable) begin
            if (i_valid) begin
              x_cur <= i_data;
              band  <= '0;
              term  <= '0;
              acc   <= '0;
              state <= S_MAC;
            end
          end else begin
            // Bypass: pass the sample through and keep the filter history clean
            o_data  <= i_data;
            o_valid <= i_valid;
            for (int b = 0; b < NUM_BANDS; b++) begin
              x1[b] <= '0;
              x2[b] <= '0;
              y1[b] <= '0;
              y2[b] <= '0;
            end
          end
        end

        S_MAC: begin
          acc <= acc_nxt;
          if (term == 3'd4) begin
            state <= S_WB;
          end else begin
            term <= term + 3'd1;
          end
        end

        S_WB: begin
          x2[band] <= x1[band];
          x1[band] <= x_cur;
          y2[band] <= y1[band];
          y1[band] <= y_sat;
          x_cur    <= y_sat;
          acc      <= '0;
          term     <= '0;
          if (band == LAST_BAND) begin
            o_data  <= y_sat;
            o_valid <= 1'b1;
            state   <= S_OUT;
          end else begin
            band  <= band + BW'(1);
            state <= S_MAC;
          end
        end

        S_OUT: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase

      if (i_valid && (state != S_IDLE)) begin
        o_overrun <= 1'b1;
      end
    end
  end

`ifdef EQ_CLIP_DETECT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_clip <= 1'b0;
    end else if (coef_wr && (i_coef_idx == 3'd7)) begin
      o_clip <= 1'b0;
    end else if ((state == S_WB) && (sat_hi || sat_lo)) begin
      o_clip <= 1'b1;
    end
  end
`endif

  assign o_busy       = (state != S_IDLE);
  assign o_coef_ready = ~o_busy;

endmodule
